// File: rtl/spi_slave_if.sv
// SPI responder: synchronises SCK/SSEL/MOSI to clk_i, presents received words on valid/ready
// and shifts out words from a one-deep holding register. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first.
module spi_slave_if #(
    parameter int                DATA_W  = 8,
    parameter int                CPOL    = 0,
    parameter int                CPHA    = 0,
    parameter logic [DATA_W-1:0] TX_IDLE = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              spi_sck_i,
    input  logic              spi_ssel_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC} state_t;
    state_t state, state_nx;

    logic [2:0]        sck_sync, ssel_sync;
    logic [1:0]        mosi_sync;
    logic              sck_rise, sck_fall, lead_stb, trail_stb, sample_stb, shift_stb;
    logic              ssel_fall, ssel_rise;
    logic              frame_start, in_frame, do_sample, do_load, do_shift, word_done;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift, tx_shifted, rx_word, hold_data;
    logic [DATA_W-2:0] rx_shift, rx_shift_nx;
    logic              hold_full;

    // NOTE: the synchronisers are deliberately not reset so they keep tracking the pins
    // during reset; the FSM needs the true SSEL level when reset releases.
    always_ff @(posedge clk_i) begin
        sck_sync  <= {sck_sync[1:0], spi_sck_i};
        ssel_sync <= {ssel_sync[1:0], spi_ssel_i};
        mosi_sync <= {mosi_sync[0], spi_mosi_i};
    end

    assign sck_rise   = sck_sync[1] & ~sck_sync[2];
    assign sck_fall   = ~sck_sync[1] & sck_sync[2];
    assign ssel_rise  = ssel_sync[1] & ~ssel_sync[2];
    assign ssel_fall  = ~ssel_sync[1] & ssel_sync[2];
    assign lead_stb   = (CPOL == 0) ? sck_rise : sck_fall;
    assign trail_stb  = (CPOL == 0) ? sck_fall : sck_rise;
    assign sample_stb = (CPHA == 0) ? lead_stb : trail_stb;
    assign shift_stb  = (CPHA == 0) ? trail_stb : lead_stb;

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ssel_fall)    state_nx = ACTIVE;
            ACTIVE:  if (ssel_rise)    state_nx = IDLE;
            RESYNC:  if (ssel_sync[1]) state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    // A reset that lands mid-frame must not resume on a stray SCK edge: wait for SSEL high.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= ssel_sync[1] ? IDLE : RESYNC;
        else         state <= state_nx;
    end

    assign frame_start = (state == IDLE) && ssel_fall;
    assign in_frame    = (state == ACTIVE) && !ssel_rise;
    assign do_sample   = in_frame && sample_stb;
    assign word_done   = do_sample && (bit_cnt == LAST_BIT);
    assign do_load     = (frame_start && (CPHA == 0)) || (in_frame && shift_stb && (bit_cnt == '0));
    assign do_shift    = in_frame && shift_stb && (bit_cnt != '0);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_word     = {mosi_sync[1], rx_shift};
    assign rx_shift_nx = rx_word[DATA_W-1:1];
    assign tx_shifted  = {1'b0, tx_shift[DATA_W-1:1]};
    assign spi_miso_o  = (state == ACTIVE) && tx_shift[0];
`else
    assign rx_word     = {rx_shift, mosi_sync[1]};
    assign rx_shift_nx = rx_word[DATA_W-2:0];
    assign tx_shifted  = {tx_shift[DATA_W-2:0], 1'b0};
    assign spi_miso_o  = (state == ACTIVE) && tx_shift[DATA_W-1];
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            rx_overrun_o  <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (!in_frame)
                bit_cnt <= '0;
            else if (do_sample)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);

            if (do_sample) rx_shift <= rx_shift_nx;

            if (do_load)       tx_shift <= hold_full ? hold_data : TX_IDLE;
            else if (do_shift) tx_shift <= tx_shifted;
            tx_underrun_o <= do_load && !hold_full;

            // A write coinciding with an underrun load is kept for the following load.
            if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid_i && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data_i;
            end

            rx_overrun_o <= word_done && rx_valid_o && !rx_ready_i;
            if (word_done) begin
                rx_data_o  <= rx_word;
                rx_valid_o <= 1'b1;
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign tx_ready_o = !hold_full;
    assign busy_o     = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a mode-0 and a mode-3 instance driven by a bit-level SPI master model,
// with expected MISO words, rx words and underrun counts derived from queue-level frame rules.
module tb_spi_slave_if;
    localparam int H = 8;  // SCK half period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       sck0, ssel0, mosi0, miso0, txv0, txr0, rxv0, rxr0, ovr0, udr0, busy0;
    logic       sck1, ssel1, mosi1, miso1, txv1, txr1, rxv1, rxr1, ovr1, udr1, busy1;
    logic [7:0] txd0, rxd0, txd1, rxd1;

    spi_slave_if #(.DATA_W(8), .CPOL(0), .CPHA(0), .TX_IDLE(8'h00)) dut0 (
        .clk_i(clk), .reset_i(rst), .spi_sck_i(sck0), .spi_ssel_i(ssel0), .spi_mosi_i(mosi0),
        .spi_miso_o(miso0), .tx_data_i(txd0), .tx_valid_i(txv0), .tx_ready_o(txr0),
        .rx_data_o(rxd0), .rx_valid_o(rxv0), .rx_ready_i(rxr0), .rx_overrun_o(ovr0),
        .tx_underrun_o(udr0), .busy_o(busy0));

    spi_slave_if #(.DATA_W(8), .CPOL(1), .CPHA(1), .TX_IDLE(8'hFF)) dut1 (
        .clk_i(clk), .reset_i(rst), .spi_sck_i(sck1), .spi_ssel_i(ssel1), .spi_mosi_i(mosi1),
        .spi_miso_o(miso1), .tx_data_i(txd1), .tx_valid_i(txv1), .tx_ready_o(txr1),
        .rx_data_o(rxd1), .rx_valid_o(rxv1), .rx_ready_i(rxr1), .rx_overrun_o(ovr1),
        .tx_underrun_o(udr1), .busy_o(busy1));

    typedef struct packed {
        logic       busy, miso, rxv, txr, ovr, udr;
        logic [7:0] rxd;
    } stat_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         udr_cnt [2] = '{0, 0};
    int         ovr_cnt [2] = '{0, 0};
    logic [7:0] txq0[$], txq1[$], rxq0[$], rxq1[$];
    logic [7:0] mosi_w[$], tx_w[$], miso_w[$];
    logic       pend0, pend1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic stat_t st(input int d);
        stat_t s;
        if (d == 0) s = '{busy0, miso0, rxv0, txr0, ovr0, udr0, rxd0};
        else        s = '{busy1, miso1, rxv1, txr1, ovr1, udr1, rxd1};
        return s;
    endfunction

    // One clk cycle: observe outputs at the falling edge, then run the tx feeders.
    task automatic tick();
        @(negedge clk);
        if (udr0 === 1'b1) udr_cnt[0] = udr_cnt[0] + 1;
        if (udr1 === 1'b1) udr_cnt[1] = udr_cnt[1] + 1;
        if (ovr0 === 1'b1) ovr_cnt[0] = ovr_cnt[0] + 1;
        if (ovr1 === 1'b1) ovr_cnt[1] = ovr_cnt[1] + 1;
        if (rxv0 === 1'b1 && rxr0) rxq0.push_back(rxd0);
        if (rxv1 === 1'b1 && rxr1) rxq1.push_back(rxd1);
        if (pend0) begin txq0.delete(0); txv0 = 1'b0; pend0 = 1'b0; end
        if (!txv0 && txq0.size() > 0) begin txv0 = 1'b1; txd0 = txq0[0]; end
        if (txv0 && txr0 === 1'b1) pend0 = 1'b1;
        if (pend1) begin txq1.delete(0); txv1 = 1'b0; pend1 = 1'b0; end
        if (!txv1 && txq1.size() > 0) begin txv1 = 1'b1; txd1 = txq1[0]; end
        if (txv1 && txr1 === 1'b1) pend1 = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input int d, input logic s_sck, input logic s_ssel, input logic s_mosi);
        if (d == 0) begin sck0 = s_sck; ssel0 = s_ssel; mosi0 = s_mosi; end
        else        begin sck1 = s_sck; ssel1 = s_ssel; mosi1 = s_mosi; end
    endtask

    task automatic set_rx_ready(input int d, input logic v);
        if (d == 0) begin
            if (v && !rxr0 && rxv0 === 1'b1) rxq0.push_back(rxd0);
            rxr0 = v;
        end else begin
            if (v && !rxr1 && rxv1 === 1'b1) rxq1.push_back(rxd1);
            rxr1 = v;
        end
    endtask

    task automatic pop_rx(input int d, output logic [31:0] v);
        v = 32'hDEAD_BEEF;
        if (d == 0 && rxq0.size() > 0) v = {24'h0, rxq0.pop_front()};
        if (d == 1 && rxq1.size() > 0) v = {24'h0, rxq1.pop_front()};
    endtask

    function automatic int rx_pending(input int d);
        return (d == 0) ? rxq0.size() : rxq1.size();
    endfunction

    task automatic check_reset(input int d, input string tag);
        stat_t s;
        s = st(d);
        check({tag, "_busy"}, s.busy, 1'b0);
        check({tag, "_miso"}, s.miso, 1'b0);
        check({tag, "_rx_valid"}, s.rxv, 1'b0);
        check({tag, "_tx_ready"}, s.txr, 1'b1);
        check({tag, "_rx_data"}, s.rxd, 8'h00);
        check({tag, "_pulses"}, {s.ovr, s.udr}, 2'b00);
    endtask

    // Bit-level SPI master: sends mosi_w MSB first, records the MISO words it samples.
    task automatic frame(input int d, input int nbits, input int reset_at);
        logic       cpol, b, m;
        logic [7:0] acc;
        cpol = (d != 0);
        acc  = 8'h00;
        miso_w.delete();
        drive(d, cpol, 1'b0, 1'b0);
        ticks(H);
        for (int i = 0; i < nbits; i++) begin
            b = mosi_w[i / 8][7 - (i % 8)];
            if (i == reset_at) begin
                rst = 1'b1;
                ticks(3);
                rst = 1'b0;
                ticks(2);
                check_reset(d, "mid_reset");
            end
            if (d == 0) begin
                drive(d, cpol, 1'b0, b);
                ticks(H);
                m = st(d).miso;
                drive(d, ~cpol, 1'b0, b);
                ticks(H);
                drive(d, cpol, 1'b0, b);
            end else begin
                drive(d, ~cpol, 1'b0, b);
                ticks(H);
                m = st(d).miso;
                drive(d, cpol, 1'b0, b);
                ticks(H);
            end
            acc = {acc[6:0], m};
            if (i % 8 == 7) miso_w.push_back(acc);
        end
        if (d == 0) ticks(H);
        if (reset_at >= 0) check("resync_busy", st(d).busy, 1'b0);
        drive(d, cpol, 1'b1, 1'b0);
        ticks(2 * H);
    endtask

    // Frame model: each word of a frame takes one load, plus one extra load at the end of a
    // CPHA=0 frame; loads consume tx_w in order and fall back to TX_IDLE with an underrun.
    task automatic run_words(input int d, input string tag, input bit chk_rx);
        int          loads, avail, exp_udr, u0;
        logic [7:0]  idle;
        logic [31:0] got;
        loads   = mosi_w.size() + ((d == 0) ? 1 : 0);
        avail   = tx_w.size();
        exp_udr = (loads > avail) ? loads - avail : 0;
        idle    = (d == 0) ? 8'h00 : 8'hFF;
        foreach (tx_w[i]) begin
            if (d == 0) txq0.push_back(tx_w[i]);
            else        txq1.push_back(tx_w[i]);
        end
        ticks(4);
        u0 = udr_cnt[d];
        frame(d, 8 * mosi_w.size(), -1);
        for (int i = 0; i < mosi_w.size(); i++) begin
            check({tag, "_miso_word"}, miso_w[i], (i < avail) ? tx_w[i] : idle);
            if (chk_rx) begin
                pop_rx(d, got);
                check({tag, "_rx_word"}, got, {24'h0, mosi_w[i]});
            end
        end
        if (chk_rx) check({tag, "_rx_extra"}, rx_pending(d), 0);
        check({tag, "_underruns"}, udr_cnt[d] - u0, exp_udr);
        check({tag, "_tx_ready"}, st(d).txr, 1'b1);
        check({tag, "_busy_after"}, st(d).busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, nt, d, o0;
        logic [31:0] got;
        rst = 1'b1;
        sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0;
        sck1 = 1'b1; ssel1 = 1'b1; mosi1 = 1'b0;
        txv0 = 1'b0; txd0 = 8'h00; rxr0 = 1'b1; pend0 = 1'b0;
        txv1 = 1'b0; txd1 = 8'h00; rxr1 = 1'b1; pend1 = 1'b0;
        ticks(6);
        rst = 1'b0;
        ticks(2);
        check_reset(0, "rst0");
        check_reset(1, "rst1");

        mosi_w = '{8'h3C};          tx_w = '{8'hA5};          run_words(0, "mode0", 1);
        mosi_w = '{8'h12, 8'h34};   tx_w = '{8'h81, 8'h7E};   run_words(1, "mode3", 1);
        mosi_w = '{8'($urandom_range(0, 255))}; tx_w.delete(); run_words(1, "underrun", 1);

        for (int k = 0; k < 4; k++) begin
            d = k % 2;
            n = $urandom_range(1, 3);
            mosi_w.delete();
            tx_w.delete();
            for (int i = 0; i < n; i++) mosi_w.push_back(8'($urandom_range(0, 255)));
            nt = $urandom_range(0, n + ((d == 0) ? 1 : 0));
            for (int i = 0; i < nt; i++) tx_w.push_back(8'($urandom_range(0, 255)));
            run_words(d, "random", 1);
        end

        set_rx_ready(0, 1'b0);
        o0 = ovr_cnt[0];
        mosi_w = '{8'h11, 8'h22};
        tx_w.delete();
        run_words(0, "overrun", 0);
        check("overrun_pulses", ovr_cnt[0] - o0, 1);
        check("overrun_data", rxd0, 8'h22);
        check("overrun_valid", rxv0, 1'b1);
        set_rx_ready(0, 1'b1);
        ticks(2);
        check("overrun_valid_clear", rxv0, 1'b0);
        pop_rx(0, got);
        check("overrun_read", got, 32'h22);

        mosi_w = '{8'($urandom_range(0, 255))};
        frame(0, 5, -1);
        check("partial_no_rx", rx_pending(0), 0);
        check("partial_valid", rxv0, 1'b0);
        mosi_w = '{8'h5A}; tx_w.delete(); run_words(0, "after_partial", 1);

        mosi_w = '{8'($urandom_range(0, 255))};
        frame(0, 8, 3);
        check("reset_frame_no_rx", rx_pending(0), 0);
        check("reset_frame_valid", rxv0, 1'b0);
        mosi_w = '{8'($urandom_range(0, 255))};
        tx_w = '{8'($urandom_range(0, 255))};
        run_words(0, "after_reset", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
